toggle_event_receiver: RTL
==========================

Name: toggle_event_receiver

Overview:
- Receiving end of a toggle-signalling link: a remote T-type flip-flop flips `toggle_in` once per event.
- This block detects each level change and turns it into one event.
- Events are buffered in a saturating pending counter and delivered on a valid/ready output.
- Each delivered event is acknowledged by flipping `ack_toggle` back to the sender.

Parameters:
- MAX_PEND, 7: maximum events held; range 1..255.
- PEND_W, 3: width of the `pending` output; must satisfy 2^PEND_W > MAX_PEND.
- CNT_W, 8: width of the delivered-event counter `evt_count`; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- toggle_in  input  1  event line; each level change (0->1 or 1->0) is one event.
- clr_ovf  input  1  clears the sticky `overflow` flag.
- evt_ready  input  1  downstream accepts an event.
- evt_valid  output  1  at least one event is pending.
- pending  output  PEND_W  number of events currently buffered.
- evt_count  output  CNT_W  total events delivered since reset.
- ack_toggle  output  1  flips once per delivered event.
- overflow  output  1  sticky flag: an event was dropped because the buffer was full.

Behaviour:
- Reset, every output and state register on the clk edge while reset=1:
  - pending=0, evt_count=0, ack_toggle=0, overflow=0.
  - The edge register tog_q (and sync stages when enabled) loads the current toggle_in.
  - Consequence: a high toggle_in at reset release is not an event.
  - Reset asserted mid-operation discards all pending events with no ack.
- Detect:
  - det = toggle_in XOR tog_q (sync output when enabled); tog_q <= toggle_in every cycle.
  - Exactly one event per level change.
  - Consecutive-cycle toggles count as separate events.
- Pop: pop = evt_valid & evt_ready.
- evt_valid is decoded from the pending register (pending != 0); it has no combinational path from evt_ready.
- Pending update per edge:
  - det & !pop: if pending < MAX_PEND then +1; else the event is dropped and overflow <= 1.
  - !det & pop: -1.
  - det & pop: unchanged. When full, this event is accepted and overflow does not set.
  - neither: hold.
- Latency: a toggle sampled at edge N gives evt_valid=1 after edge N, i.e. visible in cycle N+1 (no sync).
- On each pop:
  - evt_count <= evt_count + 1, wrapping from 2^CNT_W-1 to 0.
  - ack_toggle <= ~ack_toggle in the same edge.
- Dropped events never flip ack_toggle. The sender detects loss by comparing its toggle count with the ack count.
- overflow:
  - Set by a drop, cleared by clr_ovf.
  - Drop and clr_ovf in the same cycle: overflow ends at 1 (set wins).
- State view, all derived from pending:
  - EMPTY: pending=0.
  - PART: 0 < pending < MAX_PEND.
  - FULL: pending=MAX_PEND.
  - Transitions follow the pending update rules above; there are no other state registers.

Optional Feature:
- Macro: TOGGLE_RX_SYNC2_EN.
- Defined:
  - toggle_in passes through two synchronizer flops before tog_q/det.
  - Detection latency increases by 2 cycles: toggle sampled at edge N gives evt_valid visible in cycle N+3.
  - Sync flops load toggle_in during reset.
- Undefined: toggle_in is treated as synchronous to clk; no extra flops.

Test Plan:
- Reset with toggle_in=1, release, hold toggle_in=1 for 5 cycles -> evt_valid=0, pending=0, ack_toggle=0 throughout.
- evt_ready=1; toggle_in 0->1 at edge N -> evt_valid=1 in cycle N+1, pop at edge N+1; afterwards evt_count=1, ack_toggle=1, pending=0.
- evt_ready=0; toggle_in flips on 9 consecutive cycles (MAX_PEND=7):
  - pending reaches 7, overflow=1, ack_toggle unchanged.
  - Then evt_ready=1 for 7 cycles -> evt_count=7, ack_toggle=1 (7 flips), pending=0.
- pending=7 with evt_ready=1 while toggling every cycle for 4 cycles -> pending stays 7, overflow stays 0, evt_count +4.
- overflow=1; assert clr_ovf together with a drop -> overflow=1. Next cycle clr_ovf alone -> overflow=0.
- Wrap and reset mid-operation:
  - 256 pops with CNT_W=8 -> evt_count wraps to 0.
  - With pending=3, assert reset for 1 cycle -> pending=0, evt_valid=0, evt_count=0.
  - Repeat the second scenario with TOGGLE_RX_SYNC2_EN defined -> evt_valid first visible in cycle N+3.

Source files
------------

// File: rtl/toggle_event_receiver.sv
// toggle_event_receiver: toggle-link event receiver with saturating pending buffer; TOGGLE_RX_SYNC2_EN adds a 2-flop input synchronizer
module toggle_event_receiver #(
    parameter int MAX_PEND = 7,
    parameter int PEND_W   = 3,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              toggle_in,
    input  logic              clr_ovf,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              ack_toggle,
    output logic              overflow
);
    logic              tog_src, tog_q, tog_d, det, pop, full;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]  evt_count_q, evt_count_d;
    logic              ack_q, ack_d, overflow_q, overflow_d;
`ifdef TOGGLE_RX_SYNC2_EN
    logic [1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[0], toggle_in};
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{toggle_in}};
        else sync_q <= sync_d;
    end
    assign tog_src = sync_q[1];
`else
    assign tog_src = toggle_in;
`endif
    assign evt_valid  = pending_q != '0;
    assign pending    = pending_q;
    assign evt_count  = evt_count_q;
    assign ack_toggle = ack_q;
    assign overflow   = overflow_q;
    // A detect that coincides with a pop is absorbed even when full, so it never counts as a drop
    always_comb begin
        tog_d       = tog_src;
        det         = tog_src ^ tog_q;
        pop         = evt_valid & evt_ready;
        full        = pending_q == PEND_W'(MAX_PEND);
        pending_d   = (det & ~pop & ~full) ? pending_q + PEND_W'(1) :
                      (~det & pop) ? pending_q - PEND_W'(1) : pending_q;
        overflow_d  = (det & ~pop & full) | (overflow_q & ~clr_ovf);
        evt_count_d = evt_count_q + CNT_W'(pop);
        ack_d       = ack_q ^ pop;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q       <= toggle_in;
            pending_q   <= '0;
            evt_count_q <= '0;
            ack_q       <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tog_q       <= tog_d;
            pending_q   <= pending_d;
            evt_count_q <= evt_count_d;
            ack_q       <= ack_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule
